alu_cmd_issue: RTL and testbench

//  Command-issue stage that sits directly upstream of the 6-bit combinational ALU.

---
 rtl/alu_cmd_issue.sv | 113 +++++++++++
 tb/tb_alu_cmd_issue.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issue.sv
// Command-issue stage for the combinational ALU: reads operands from a small register file,
// drives registered ALU inputs, writes back the result and returns it on a valid/ready port.
module alu_cmd_issue #(
    parameter  int WIDTH = 6,
    parameter  int NREG  = 4,
    localparam int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [3:0]       i_cmd_ctrl,
    input  logic             i_cmd_ldi,
    input  logic [AW-1:0]    i_cmd_rd,
    input  logic [AW-1:0]    i_cmd_rs1,
    input  logic [AW-1:0]    i_cmd_rs2,
    input  logic [WIDTH-1:0] i_cmd_imm,
    output logic [3:0]       o_alu_ctrl,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    input  logic [WIDTH-1:0] i_alu_y,
    input  logic             i_alu_carry,
    input  logic             i_alu_zero,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_data,
    output logic             o_rsp_carry,
    output logic             o_rsp_zero,
    output logic [AW-1:0]    o_rsp_rd
);

    // state  | meaning
    // S_IDLE | waiting for a command, cmd_ready high
    // S_EXEC | ALU evaluating registered operands, result captured at end of cycle
    // S_RESP | response held until rsp_ready; may accept next command in the same cycle
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t           r_state;
    logic             r_ldi;
    logic [WIDTH-1:0] r_imm;
    logic [AW-1:0]    r_rd;
    logic [WIDTH-1:0] r_regs [NREG];

    logic             w_accept;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_zero;

    assign o_cmd_ready = (r_state == S_IDLE) | ((r_state == S_RESP) & i_rsp_ready);
    assign w_accept    = i_cmd_valid & o_cmd_ready;

    // LDI bypasses the ALU entirely; its flags come from the immediate.
    assign w_result = r_ldi ? r_imm : i_alu_y;
    assign w_carry  = r_ldi ? 1'b0 : i_alu_carry;
    assign w_zero   = r_ldi ? (r_imm == '0) : i_alu_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ldi       <= 1'b0;
            r_imm       <= '0;
            r_rd        <= '0;
            o_alu_ctrl  <= '0;
            o_alu_a     <= '0;
            o_alu_b     <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_carry <= 1'b0;
            o_rsp_zero  <= 1'b0;
            o_rsp_rd    <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            // Operands are read here; the previous write-back already landed one edge earlier.
            if (w_accept) begin
                o_alu_ctrl <= i_cmd_ctrl;
                o_alu_a    <= r_regs[i_cmd_rs1];
                o_alu_b    <= r_regs[i_cmd_rs2];
                r_ldi      <= i_cmd_ldi;
                r_imm      <= i_cmd_imm;
                r_rd       <= i_cmd_rd;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_regs[r_rd] <= w_result;
                    o_rsp_data   <= w_result;
                    o_rsp_carry  <= w_carry;
                    o_rsp_zero   <= w_zero;
                    o_rsp_rd     <= r_rd;
                    o_rsp_valid  <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        r_state     <= w_accept ? S_EXEC : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue: behavioural ALU plus a register-array reference model,
// one task per scenario, randomized operands.
module tb_alu_cmd_issue;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_ctrl;
    logic       cmd_ldi;
    logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
    logic [5:0] cmd_imm;
    logic [3:0] alu_ctrl;
    logic [5:0] alu_a, alu_b, alu_y;
    logic       alu_carry, alu_zero;
    logic       rsp_valid, rsp_ready;
    logic [5:0] rsp_data;
    logic       rsp_carry, rsp_zero;
    logic [1:0] rsp_rd;

    int n_cmp = 0;
    int n_err = 0;

    logic [5:0] mdl [4];
    logic [7:0] last_exp;
    logic [7:0] last_act;
    logic [1:0] last_rd;
    logic [5:0] last_a, last_b;

    alu_cmd_issue #(.WIDTH(6), .NREG(4)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_ctrl(cmd_ctrl), .i_cmd_ldi(cmd_ldi),
        .i_cmd_rd(cmd_rd), .i_cmd_rs1(cmd_rs1), .i_cmd_rs2(cmd_rs2), .i_cmd_imm(cmd_imm),
        .o_alu_ctrl(alu_ctrl), .o_alu_a(alu_a), .o_alu_b(alu_b),
        .i_alu_y(alu_y), .i_alu_carry(alu_carry), .i_alu_zero(alu_zero),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_carry(rsp_carry), .o_rsp_zero(rsp_zero), .o_rsp_rd(rsp_rd)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {carry, y}. SUB carry is the borrow out.
    function automatic logic [6:0] alu_fn(input logic [3:0] c, input logic [5:0] a, input logic [5:0] b);
        logic [6:0] s;
        case (c)
            4'b0000: s = {1'b0, a & b};
            4'b0001: s = {1'b0, a | b};
            4'b0010: s = {1'b0, a} + {1'b0, b};
            4'b0110: s = {1'b0, a} - {1'b0, b};
            4'b1000: s = {6'b0, ($signed(a) < $signed(b))};
            default: s = 7'b0;
        endcase
        return s;
    endfunction

    always_comb begin
        {alu_carry, alu_y} = alu_fn(alu_ctrl, alu_a, alu_b);
        alu_zero = (alu_y == 6'b0);
    end

    // Expected response {zero, carry, data}
    function automatic logic [7:0] exp_rsp(input logic ldi, input logic [3:0] c,
                                           input logic [5:0] a, input logic [5:0] b, input logic [5:0] imm);
        logic [6:0] s;
        if (ldi) return {(imm == 6'b0), 1'b0, imm};
        s = alu_fn(c, a, b);
        return {(s[5:0] == 6'b0), s[6], s[5:0]};
    endfunction

    function automatic logic [5:0] rnd6();
        logic [31:0] t;
        t = $urandom;
        return t[5:0];
    endfunction

    function automatic logic [1:0] rnd2();
        logic [31:0] t;
        t = $urandom;
        return t[1:0];
    endfunction

    function automatic logic [3:0] rnd_ctrl();
        logic [31:0] t;
        t = $urandom_range(0, 4);
        case (t)
            0: return 4'b0000;
            1: return 4'b0001;
            2: return 4'b0010;
            3: return 4'b0110;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic clear_mdl();
        for (int i = 0; i < 4; i++) mdl[i] = 6'b0;
    endtask

    task automatic junk_fields();
        cmd_ctrl = rnd_ctrl(); cmd_ldi = rnd6() > 6'd40;
        cmd_rd = rnd2(); cmd_rs1 = rnd2(); cmd_rs2 = rnd2(); cmd_imm = rnd6();
    endtask

    // Issue one command from IDLE, check EXEC operands and the response, then one more edge.
    task automatic do_cmd(input logic ldi, input logic [3:0] c, input logic [1:0] rd,
                          input logic [1:0] rs1, input logic [1:0] rs2, input logic [5:0] imm, input string tag);
        logic [7:0] e;
        logic [5:0] ea, eb;
        int n;
        ea = mdl[rs1];
        eb = mdl[rs2];
        e  = exp_rsp(ldi, c, ea, eb, imm);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ldi = ldi; cmd_ctrl = c; cmd_rd = rd;
        cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            n_cmp++; n_err++;
            $display("FAIL %s accept: cmd_ready never rose", tag);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        junk_fields();
        mdl[rd] = e[5:0];
        last_exp = e; last_rd = rd; last_a = alu_a; last_b = alu_b;
        n_cmp++; if (alu_ctrl !== c) begin n_err++; $display("FAIL %s alu_ctrl: got %h exp %h", tag, alu_ctrl, c); end
        n_cmp++; if (alu_a !== ea) begin n_err++; $display("FAIL %s alu_a: got %h exp %h", tag, alu_a, ea); end
        n_cmp++; if (alu_b !== eb) begin n_err++; $display("FAIL %s alu_b: got %h exp %h", tag, alu_b, eb); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL %s rsp_valid_exec: got %b exp 0", tag, rsp_valid); end
        @(posedge clk); #1;
        last_act = {rsp_zero, rsp_carry, rsp_data};
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL %s rsp_valid: got %b exp 1", tag, rsp_valid); end
        n_cmp++; if ({rsp_zero, rsp_carry, rsp_data} !== e)
            begin n_err++; $display("FAIL %s rsp z/c/data: got %b/%b/%h exp %b/%b/%h", tag, rsp_zero, rsp_carry, rsp_data, e[7], e[6], e[5:0]); end
        n_cmp++; if (rsp_rd !== rd) begin n_err++; $display("FAIL %s rsp_rd: got %0d exp %0d", tag, rsp_rd, rd); end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL %s cmd_ready: got %b exp 1", tag, cmd_ready); end
        n_cmp++; if ({alu_ctrl, alu_a, alu_b} !== 16'h0) begin n_err++; $display("FAIL %s alu_regs: got %h/%h/%h exp 0", tag, alu_ctrl, alu_a, alu_b); end
        n_cmp++; if ({rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_rd} !== 11'h0)
            begin n_err++; $display("FAIL %s rsp_regs: got v%b d%h c%b z%b rd%0d exp 0", tag, rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_rd); end
    endtask

    task automatic test_reset();
        rst = 1'b1; rsp_ready = 1'b1; cmd_valid = 1'b0; junk_fields();
        clear_mdl();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        #2 rst = 1'b0;
        do_cmd(1'b1, 4'b0000, 2'd1, 2'd0, 2'd0, rnd6() | 6'h01, "rst_ldi1");
        rsp_ready = 1'b0;
        do_cmd(1'b0, 4'b0001, 2'd0, 2'd1, 2'd1, 6'h00, "rst_or0");
        @(negedge clk); #2 rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        #3 rst = 1'b0;
        clear_mdl();
        rsp_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            do_cmd(1'b0, 4'b0010, 2'(r), 2'(r), 2'(r), rnd6(), "rst_read");
            n_cmp++; if (last_act[5:0] !== 6'h00) begin n_err++; $display("FAIL rst_read r%0d: got %h exp 00", r, last_act[5:0]); end
        end
    endtask

    task automatic test_ldi_add();
        do_cmd(1'b1, 4'b0000, 2'd1, 2'd0, 2'd0, 6'h15, "ldi_r1");
        do_cmd(1'b1, 4'b0000, 2'd2, 2'd0, 2'd0, 6'h2B, "ldi_r2");
        do_cmd(1'b0, 4'b0010, 2'd3, 2'd1, 2'd2, 6'h00, "add_r3");
        n_cmp++; if ({last_a, last_b} !== {6'h15, 6'h2B}) begin n_err++; $display("FAIL add_ops: got %h/%h exp 15/2b", last_a, last_b); end
        n_cmp++; if (last_act !== 8'b1100_0000) begin n_err++; $display("FAIL add_rsp z/c/data: got %b exp 11000000", last_act); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] q [$];
        logic [9:0] h;
        logic [7:0] e;
        logic [1:0] rd, rs1, rs2;
        logic [3:0] c;
        logic [5:0] imm;
        logic       ldi;
        int sent, got;
        sent = 0; got = 0;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 17; cyc++) begin
            @(negedge clk);
            n_cmp++; if (cmd_ready !== (cyc % 2 == 0)) begin n_err++; $display("FAIL b2b cmd_ready cyc%0d: got %b exp %b", cyc, cmd_ready, (cyc % 2 == 0)); end
            if (rsp_valid) begin
                got++;
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL b2b unexpected rsp cyc%0d: got %h exp none", cyc, rsp_data); end
                else begin
                    h = q.pop_front();
                    if ({rsp_rd, rsp_zero, rsp_carry, rsp_data} !== h)
                        begin n_err++; $display("FAIL b2b rsp cyc%0d: got %h exp %h", cyc, {rsp_rd, rsp_zero, rsp_carry, rsp_data}, h); end
                end
            end
            if (cmd_ready && sent < 8) begin
                ldi = rnd6() > 6'd42; c = rnd_ctrl(); rd = rnd2(); rs1 = rnd2(); rs2 = rnd2(); imm = rnd6();
                e = exp_rsp(ldi, c, mdl[rs1], mdl[rs2], imm);
                mdl[rd] = e[5:0];
                q.push_back({rd, e});
                cmd_valid = 1'b1; cmd_ldi = ldi; cmd_ctrl = c; cmd_rd = rd;
                cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
                sent++;
            end else if (sent < 8) begin
                cmd_valid = 1'b1; junk_fields();
            end else begin
                cmd_valid = 1'b0;
            end
        end
        n_cmp++; if (got != 8 || q.size() != 0) begin n_err++; $display("FAIL b2b count: got %0d rsps exp 8", got); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        logic [1:0] vr;
        logic [5:0] vimm;
        rsp_ready = 1'b0;
        do_cmd(1'b0, rnd_ctrl(), rnd2(), rnd2(), rnd2(), 6'h00, "stall_cmd");
        vr = last_rd ^ 2'd1;
        vimm = ~mdl[vr];
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ldi = 1'b1; cmd_ctrl = 4'b0010; cmd_rd = vr;
        cmd_rs1 = vr; cmd_rs2 = vr; cmd_imm = vimm;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL stall cmd_ready k%0d: got %b exp 0", k, cmd_ready); end
            n_cmp++; if ({rsp_valid, rsp_rd, rsp_zero, rsp_carry, rsp_data} !== {1'b1, last_rd, last_exp})
                begin n_err++; $display("FAIL stall rsp k%0d: got %h exp %h", k, {rsp_valid, rsp_rd, rsp_zero, rsp_carry, rsp_data}, {1'b1, last_rd, last_exp}); end
            n_cmp++; if ({alu_a, alu_b} !== {last_a, last_b}) begin n_err++; $display("FAIL stall alu_ab k%0d: got %h/%h exp %h/%h", k, alu_a, alu_b, last_a, last_b); end
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL stall release rsp_valid: got %b exp 0", rsp_valid); end
        do_cmd(1'b0, 4'b0001, vr, vr, vr, 6'h00, "stall_readback");
    endtask

    task automatic test_raw();
        do_cmd(1'b1, 4'b0000, 2'd1, 2'd0, 2'd0, 6'h3F, "raw_ldi");
        do_cmd(1'b0, 4'b0110, 2'd1, 2'd1, 2'd1, 6'h00, "raw_sub");
        do_cmd(1'b0, 4'b0010, 2'd2, 2'd1, 2'd1, 6'h00, "raw_add");
        n_cmp++; if ({last_act[7], last_act[5:0]} !== 7'b1_000000) begin n_err++; $display("FAIL raw_add z/data: got %b/%h exp 1/00", last_act[7], last_act[5:0]); end
    endtask

    task automatic test_reset_exec();
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ldi = 1'b1; cmd_ctrl = 4'b0000; cmd_rd = 2'd2;
        cmd_rs1 = 2'd0; cmd_rs2 = 2'd0; cmd_imm = 6'h07;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        clear_mdl();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_exec rsp_valid k%0d: got %b exp 0", k, rsp_valid); end
        end
        do_cmd(1'b0, 4'b0010, 2'd2, 2'd2, 2'd2, 6'h00, "rst_exec_read");
        n_cmp++; if (last_act[5:0] !== 6'h00) begin n_err++; $display("FAIL rst_exec r2: got %h exp 00", last_act[5:0]); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            do_cmd(rnd6() > 6'd45, rnd_ctrl(), rnd2(), rnd2(), rnd2(), rnd6(), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_ldi_add();
        test_back_to_back();
        test_stall();
        test_raw();
        test_reset_exec();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
